// File: rtl/stack_addressing_unit.sv
// Next-address selector with PC register and a bounded LIFO return stack.
// Address is combinational; PC, stack depth and the sticky error flag are registered.
module stack_addressing_unit #(
  parameter int unsigned     AW           = 16,
  parameter int unsigned     IW           = 8,
  parameter int unsigned     DEPTH        = 8,
  parameter logic [AW-1:0]   RESET_VECTOR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AW-1:0]              Rside,
  input  logic [IW-1:0]              Iside,
  input  logic                       ResetPC,
  input  logic                       PCplusI,
  input  logic                       PCplus1,
  input  logic                       Iplus0,
  input  logic                       Rplus0,
  input  logic                       Call,
  input  logic                       Ret,
  input  logic                       PCenable,
  output logic [AW-1:0]              Address,
  output logic [AW-1:0]              PCout,
  output logic [$clog2(DEPTH):0]     stack_count,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [AW-1:0] stack_q [DEPTH];
  logic          push_c;

  logic                 full_c;
  logic                 empty_c;
  logic [AW-1:0]        pc_inc_c;
  logic [AW-1:0]        tos_c;
  logic signed [IW-1:0] imm_s;
  logic [AW-1:0]        imm_sext_c;
  logic [AW-1:0]        imm_zext_c;
  logic [PW-1:0]        rd_idx_c;
  logic [PW-1:0]        wr_idx_c;

  assign full_c     = (cnt_q == CW'(DEPTH));
  assign empty_c    = (cnt_q == '0);
  assign pc_inc_c   = pc_q + AW'(1);
  assign imm_s      = $signed(Iside);
  assign imm_sext_c = AW'(imm_s);
  assign imm_zext_c = AW'(Iside);
  assign rd_idx_c   = PW'(cnt_q - CW'(1));
  assign wr_idx_c   = PW'(cnt_q);
  assign tos_c      = stack_q[rd_idx_c];

  // Fixed-priority next-address mux; an empty-stack return falls through to PC+1.
  always_comb begin
    Address = pc_q;
    if (ResetPC)      Address = RESET_VECTOR;
    else if (Ret)     Address = empty_c ? pc_inc_c : tos_c;
    else if (Call)    Address = Rside;
    else if (PCplusI) Address = pc_q + imm_sext_c;
    else if (PCplus1) Address = pc_inc_c;
    else if (Iplus0)  Address = imm_zext_c;
    else if (Rplus0)  Address = Rside;
  end

  // Stack bookkeeping: only the winning select acts, and only when PCenable is high.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    push_c = 1'b0;
    if (PCenable) begin
      pc_d = Address;
      if (ResetPC) begin
        cnt_d = '0;
        err_d = 1'b0;
      end else if (Ret) begin
        if (empty_c) err_d = 1'b1;
        else         cnt_d = cnt_q - CW'(1);
      end else if (Call) begin
        if (full_c) begin
          err_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          push_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (rst_n && push_c) stack_q[wr_idx_c] <= pc_inc_c;
  end

  assign PCout       = pc_q;
  assign stack_count = cnt_q;
  assign stack_full  = full_c;
  assign stack_empty = empty_c;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_stack_addressing_unit.sv
// Vector-table bench for stack_addressing_unit (AW=16, IW=8, DEPTH=8, RESET_VECTOR=0).
// Address is checked before each edge; registered results go through a scoreboard queue.
module tb_stack_addressing_unit;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_R0   = 7'b0000001;
  localparam logic [6:0] S_I0   = 7'b0000010;
  localparam logic [6:0] S_P1   = 7'b0000100;
  localparam logic [6:0] S_PI   = 7'b0001000;
  localparam logic [6:0] S_CALL = 7'b0010000;
  localparam logic [6:0] S_RET  = 7'b0100000;
  localparam logic [6:0] S_RST  = 7'b1000000;

  typedef struct {
    logic        rstn;
    logic        pcen;
    logic [6:0]  sel;
    logic [15:0] rside;
    logic [7:0]  iside;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    logic [3:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] pc;
    logic [3:0]  cnt;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] Rside;
  logic [7:0]  Iside;
  logic        ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, Call, Ret, PCenable;
  logic [15:0] Address, PCout;
  logic [3:0]  stack_count;
  logic        stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  stack_addressing_unit #(.AW(16), .IW(8), .DEPTH(8), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .Rside(Rside), .Iside(Iside),
    .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1), .Iplus0(Iplus0),
    .Rplus0(Rplus0), .Call(Call), .Ret(Ret), .PCenable(PCenable),
    .Address(Address), .PCout(PCout), .stack_count(stack_count),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rstn, input logic pcen, input logic [6:0] sel,
                     input logic [15:0] rside, input logic [7:0] iside,
                     input logic [15:0] ea, input logic [15:0] epc,
                     input logic [3:0] ecnt, input logic eerr);
    vec_t v;
    v.rstn = rstn; v.pcen = pcen; v.sel = sel; v.rside = rside; v.iside = iside;
    v.exp_addr = ea; v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_err = eerr;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; PCenable = 1'b0; Rside = '0; Iside = '0;
    {ResetPC, Ret, Call, PCplusI, PCplus1, Iplus0, Rplus0} = '0;

    // reset, increment, signed immediate, priority and hold
    add(0, 0, S_RST,  16'h0000, 8'h00, 16'h0000, 16'h0000, 0, 0);
    add(1, 1, S_P1,   16'h0000, 8'h00, 16'h0001, 16'h0001, 0, 0);
    add(1, 1, S_P1,   16'h0000, 8'h00, 16'h0002, 16'h0002, 0, 0);
    add(1, 1, S_P1,   16'h0000, 8'h00, 16'h0003, 16'h0003, 0, 0);
    add(1, 1, S_PI,   16'h0000, 8'hFE, 16'h0001, 16'h0001, 0, 0);
    add(1, 1, S_P1 | S_I0 | S_R0, 16'h5555, 8'h44, 16'h0002, 16'h0002, 0, 0);
    add(1, 1, S_NONE, 16'h5555, 8'h44, 16'h0002, 16'h0002, 0, 0);
    add(1, 0, S_P1,   16'h0000, 8'h00, 16'h0003, 16'h0002, 0, 0);
    // call / return pair, then call+ret together
    add(1, 1, S_I0,   16'h0000, 8'h10, 16'h0010, 16'h0010, 0, 0);
    add(1, 1, S_CALL, 16'h0400, 8'h00, 16'h0400, 16'h0400, 1, 0);
    add(1, 1, S_RET,  16'h0000, 8'h00, 16'h0011, 16'h0011, 0, 0);
    add(1, 1, S_CALL | S_P1, 16'h0500, 8'h00, 16'h0500, 16'h0500, 1, 0);
    add(1, 1, S_CALL | S_RET, 16'h0700, 8'h00, 16'h0012, 16'h0012, 0, 0);
    // eight nested calls with non-stack cycles in the middle
    for (int k = 0; k < 8; k++) begin
      add(1, 1, S_CALL, 16'(16'h1000 * (k + 1)), 8'h00, 16'(16'h1000 * (k + 1)),
          16'(16'h1000 * (k + 1)), 4'(k + 1), 0);
      if (k == 3) begin
        add(1, 0, S_RET,  16'h0000, 8'h00, 16'h3001, 16'h4000, 4, 0);
        add(1, 0, S_CALL, 16'h0abc, 8'h00, 16'h0abc, 16'h4000, 4, 0);
        add(1, 1, S_NONE, 16'h0000, 8'h00, 16'h4000, 16'h4000, 4, 0);
      end
    end
    add(1, 1, S_CALL, 16'h0900, 8'h00, 16'h0900, 16'h0900, 8, 1);
    for (int j = 7; j >= 0; j--)
      add(1, 1, S_RET, 16'h0000, 8'h00, (j == 0) ? 16'h0013 : 16'(16'h1000 * j + 1),
          (j == 0) ? 16'h0013 : 16'(16'h1000 * j + 1), 4'(j), 1);
    // underflow and sticky error clear
    add(1, 1, S_RST,  16'h0000, 8'h00, 16'h0000, 16'h0000, 0, 0);
    add(1, 1, S_I0,   16'h0000, 8'h20, 16'h0020, 16'h0020, 0, 0);
    add(1, 1, S_RET,  16'h0000, 8'h00, 16'h0021, 16'h0021, 0, 1);
    add(1, 1, S_P1,   16'h0000, 8'h00, 16'h0022, 16'h0022, 0, 1);
    add(1, 0, S_RST,  16'h0000, 8'h00, 16'h0000, 16'h0022, 0, 1);
    add(1, 1, S_RST,  16'h0000, 8'h00, 16'h0000, 16'h0000, 0, 0);
    // wraparound, zero/sign extension, disabled call
    add(1, 1, S_R0,   16'hFFFF, 8'h00, 16'hFFFF, 16'hFFFF, 0, 0);
    add(1, 1, S_P1,   16'h0000, 8'h00, 16'h0000, 16'h0000, 0, 0);
    add(1, 1, S_I0,   16'h0000, 8'h80, 16'h0080, 16'h0080, 0, 0);
    add(1, 1, S_PI,   16'h0000, 8'h80, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, S_CALL, 16'h1234, 8'h00, 16'h1234, 16'h0000, 0, 0);
    add(1, 1, S_PI,   16'h0000, 8'h7F, 16'h007F, 16'h007F, 0, 0);
    // reset in the middle of a call chain
    add(1, 1, S_CALL, 16'h0100, 8'h00, 16'h0100, 16'h0100, 1, 0);
    add(1, 1, S_CALL, 16'h0200, 8'h00, 16'h0200, 16'h0200, 2, 0);
    add(1, 1, S_CALL, 16'h0300, 8'h00, 16'h0300, 16'h0300, 3, 0);
    add(0, 1, S_CALL, 16'h0400, 8'h00, 16'h0400, 16'h0000, 0, 0);
    add(1, 1, S_RET,  16'h0000, 8'h00, 16'h0001, 16'h0001, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst_n = vecs[i].rstn; PCenable = vecs[i].pcen;
      Rside = vecs[i].rside; Iside = vecs[i].iside;
      {ResetPC, Ret, Call, PCplusI, PCplus1, Iplus0, Rplus0} = vecs[i].sel;
      #1;
      check("address", i, 32'(Address), 32'(vecs[i].exp_addr));
      e.idx = i; e.pc = vecs[i].exp_pc; e.cnt = vecs[i].exp_cnt; e.err = vecs[i].exp_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("scoreboard_underrun", i, 32'(1), 32'(0));
      end else begin
        got = sb.pop_front();
        check("pcout", got.idx, 32'(PCout), 32'(got.pc));
        check("stack_count", got.idx, 32'(stack_count), 32'(got.cnt));
        check("stack_err", got.idx, 32'(stack_err), 32'(got.err));
        check("stack_full", got.idx, 32'(stack_full), 32'(got.cnt == 4'd8));
        check("stack_empty", got.idx, 32'(stack_empty), 32'(got.cnt == 4'd0));
      end
    end
    check("scoreboard_drained", -1, 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_addressing_unit.md
STACK_ADDRESSING_UNIT -- requirements
Module: stack_addressing_unit

Interface
REQ-001 The block SHALL have parameter AW, default 16: address/PC width.
REQ-002 The block SHALL have parameter IW, default 8: immediate width, with 1 <= IW <= AW.
REQ-003 The block SHALL have parameter DEPTH, default 8: return-stack entries, a power of 2 and >= 2.
REQ-004 The block SHALL have parameter RESET_VECTOR, default 0: PC value after reset, AW bits wide.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 The block SHALL have port Rside, input, AW bits: register-file operand.
REQ-008 The block SHALL have port Iside, input, IW bits: instruction immediate.
REQ-009 The block SHALL have ports ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, Call and Ret, each an input of 1 bit: address-select controls.
REQ-010 The block SHALL have port PCenable, input, 1 bit: PC load and stack-operation enable.
REQ-011 The block SHALL have port Address, output, AW bits: the next address, combinational.
REQ-012 The block SHALL have port PCout, output, AW bits: the current PC register.
REQ-013 The block SHALL have port stack_count, output, $clog2(DEPTH)+1 bits: number of valid stack entries.
REQ-014 The block SHALL have ports stack_full and stack_empty, each an output of 1 bit: stack status flags.
REQ-015 The block SHALL have port stack_err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-016 Address SHALL be selected in the same cycle, by fixed priority: ResetPC > Ret > Call > PCplusI > PCplus1 > Iplus0 > Rplus0 > hold.
REQ-017 ResetPC SHALL select RESET_VECTOR.
REQ-018 Ret with a non-empty stack SHALL select the top-of-stack entry.
REQ-019 Ret with an empty stack SHALL select PCout+1.
REQ-020 Call SHALL select Rside as the target.
REQ-021 PCplusI SHALL select PCout + sign-extended Iside.
REQ-022 PCplus1 SHALL select PCout+1.
REQ-023 Iplus0 SHALL select zero-extended Iside.
REQ-024 Rplus0 SHALL select Rside.
REQ-025 With no select asserted, Address SHALL equal PCout.
REQ-026 All address arithmetic SHALL be modulo 2^AW, with no carry out; PCout=all-ones with PCplus1 yields 0.
REQ-027 On a rising edge with PCenable=1, PC SHALL load Address; with PCenable=0, PC SHALL hold; latency from Address to PCout is 1 cycle.
REQ-028 Stack operations SHALL occur only on edges with PCenable=1; with PCenable=0, stack and flags SHALL be unchanged regardless of Call/Ret.
REQ-029 Call, not full: PCout+1 SHALL be pushed, and stack_count SHALL increment next cycle.
REQ-030 Call, full: the jump SHALL still occur, the push SHALL be dropped, contents SHALL be unchanged, and stack_err SHALL be set.
REQ-031 Ret, not empty: the top entry SHALL be popped, and stack_count SHALL decrement.
REQ-032 Ret, empty: no pop SHALL occur, and stack_err SHALL be set.
REQ-033 Call and Ret asserted together: Ret SHALL win per priority (pop only, no push).
REQ-034 Any other select asserted with Call/Ret SHALL be ignored for stack purposes; only the winning select acts.
REQ-035 ResetPC with PCenable=1 SHALL set PC to RESET_VECTOR, stack_count to 0, and stack_err to 0; entry contents need not be cleared.
REQ-036 stack_full SHALL equal (stack_count==DEPTH), and stack_empty SHALL equal (stack_count==0); both are derived from registered state only.
REQ-037 stack_err SHALL remain 1 until rst_n=0 or ResetPC with PCenable=1.
REQ-038 The stack SHALL be LIFO, and entries SHALL survive any number of non-stack cycles.

Reset
REQ-039 On a rising edge with rst_n=0, the block SHALL set PCout=RESET_VECTOR, stack_count=0, stack_empty=1, stack_full=0, and stack_err=0.
REQ-040 rst_n SHALL override all controls, including PCenable and any Call/Ret/ResetPC in the same cycle.
REQ-041 While rst_n=0, Address SHALL remain combinational per REQ-016, but no state SHALL update except the reset values.
REQ-042 Reset asserted mid-sequence (e.g. during a nested call chain) SHALL discard all stack entries; the first Ret after reset SHALL be an underflow.

Verification
REQ-043 The bench SHALL cover: reset, then PCplus1 with PCenable=1 for 3 cycles -> PCout=0,1,2,3; then PCplusI with Iside=8'hFE -> PCout=1.
REQ-044 The bench SHALL cover: PCout=16'h0010, Call with Rside=16'h0400 -> PCout=16'h0400, stack_count=1; then Ret -> PCout=16'h0011, stack_count=0.
REQ-045 The bench SHALL cover: 8 nested Calls (DEPTH=8) -> stack_full=1, stack_err=0; a 9th Call with Rside=16'h0900 -> PCout=16'h0900, stack_count=8, stack_err=1; then 8 Rets return in LIFO order.
REQ-046 The bench SHALL cover: Ret on an empty stack at PCout=16'h0020 -> PCout=16'h0021, stack_count=0, stack_err=1; then ResetPC with PCenable=1 -> PCout=0, stack_err=0.
REQ-047 The bench SHALL cover: PCout=16'hFFFF, PCplus1 -> PCout=16'h0000; Iplus0 with Iside=8'h80 -> PCout=16'h0080; Call with PCenable=0 -> PCout and stack_count unchanged.
REQ-048 The bench SHALL cover: 3 Calls, then rst_n=0 for 1 cycle with Call asserted -> PCout=RESET_VECTOR, stack_count=0; then Ret -> stack_err=1.
